rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port (RegWrite/Write_reg/Write_data) and shares it between
//  the pipeline writeback path (P) and the multicycle unit (M: mul/div, memory).

---
 rtl/rf_ctrl_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/rf_wb_arbiter.sv | 113 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and widths for the register-file write-port control slice.
// Holds the default widths, the write request bundle and the grant encoding.
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_P,
    GNT_M
  } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers reserved by the multicycle unit.
// Ports: set (reserve), clr (M writeback), wb_* (in-flight write), chk_* (decode).
module rf_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_valid,
  input  logic [REG_AW-1:0]        set_addr,
  input  logic                     clr_valid,
  input  logic [REG_AW-1:0]        clr_addr,
  input  logic                     wb_we,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [REG_AW-1:0]        chk_addr1,
  input  logic [REG_AW-1:0]        chk_addr2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic [(1<<REG_AW)-1:0]   busy_mask,
  output logic                     rsv_err
);

  localparam int NR = 1 << REG_AW;

  logic          set_en;
  logic          err_nxt;
  logic [NR-1:0] mask_nxt;

  // Clear first, then set, so a same-cycle set wins.
  always_comb begin
    set_en   = set_valid && (set_addr != '0);
    mask_nxt = busy_mask;
    if (clr_valid) mask_nxt[clr_addr] = 1'b0;
    if (set_en)    mask_nxt[set_addr] = 1'b1;
  end

  assign err_nxt = set_en && busy_mask[set_addr]
                && !(clr_valid && (clr_addr == set_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
      rsv_err   <= 1'b0;
    end else begin
      busy_mask <= mask_nxt;
      rsv_err   <= err_nxt;
    end
  end

  // In-flight term covers the cycle before the regfile commit.
  assign chk_busy1 = (chk_addr1 != '0)
                  && (busy_mask[chk_addr1]
                   || (wb_we && (wb_addr == chk_addr1)));
  assign chk_busy2 = (chk_addr2 != '0)
                  && (busy_mask[chk_addr2]
                   || (wb_we && (wb_addr == chk_addr2)));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: P has priority, M wins after MAX_WAIT losses.
// Ports: p_*/m_* requests, rsv_* reservations, chk_* hazards, rf_* write port.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic [REG_AW-1:0]      p_waddr,
  input  logic [XLEN-1:0]        p_wdata,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [REG_AW-1:0]      m_waddr,
  input  logic [XLEN-1:0]        m_wdata,
  input  logic                   rsv_valid,
  input  logic [REG_AW-1:0]      rsv_addr,
  output logic                   rsv_err,
  input  logic [REG_AW-1:0]      chk_addr1,
  input  logic [REG_AW-1:0]      chk_addr2,
  output logic                   chk_busy1,
  output logic                   chk_busy2,
  output logic                   rf_we,
  output logic [REG_AW-1:0]      rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [(1<<REG_AW)-1:0] busy_mask
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              at_max;
  logic              p_win;
  logic              m_win;
  grant_e            gnt;
  logic [REG_AW-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  // rst_n gating keeps both readies low while in reset.
  always_comb begin
    at_max   = (wait_cnt == WMAX);
    p_win    = rst_n && p_valid && !(at_max && m_valid);
    m_win    = rst_n && m_valid && !p_win;
    gnt      = GNT_NONE;
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      p_win: begin
        gnt      = GNT_P;
        sel_addr = p_waddr;
        sel_data = p_wdata;
      end
      m_win: begin
        gnt      = GNT_M;
        sel_addr = m_waddr;
        sel_data = m_wdata;
      end
      default: ;
    endcase
  end

  assign p_ready = p_win;
  assign m_ready = m_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (m_valid && !m_win) begin
      if (!at_max) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // x0 grants complete the handshake but never raise rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt != GNT_NONE) begin
      rf_we    <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  rf_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (m_win),
    .clr_addr  (m_waddr),
    .wb_we     (rf_we),
    .wb_addr   (rf_waddr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .busy_mask (busy_mask),
    .rsv_err   (rsv_err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
// Expected writes are queued per cycle and compared one cycle later.
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  localparam int MAXW = 3;

  typedef struct {
    logic    we;
    wb_req_t req;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, p_ready;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        m_valid, m_ready;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        rsv_valid, rsv_err;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q[$];
  int          mw;
  logic [31:0] mmask;
  logic        mwe, merr;
  logic [4:0]  mwaddr;
  logic        last_p, last_m, last_cb1, last_cb2;
  logic [31:0] saved_mask;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .XLEN     (32),
    .REG_AW   (5),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_waddr   (p_waddr),
    .p_wdata   (p_wdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_waddr   (m_waddr),
    .m_wdata   (m_wdata),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_err   (rsv_err),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mw    = 0;
    mmask = '0;
    mwe   = 1'b0;
    merr  = 1'b0;
  endtask

  // Called just after inputs are driven (posedge+1); returns at next posedge+1.
  task automatic cyc();
    logic pg, mg, cb1, cb2, rs;
    exp_t e;
    #1;
    pg  = p_valid && !((mw == MAXW) && m_valid);
    mg  = m_valid && !pg;
    cb1 = (chk_addr1 != 0)
       && (mmask[chk_addr1] || (mwe && mwaddr == chk_addr1));
    cb2 = (chk_addr2 != 0)
       && (mmask[chk_addr2] || (mwe && mwaddr == chk_addr2));
    check("p_ready", 64'(p_ready), 64'(pg));
    check("m_ready", 64'(m_ready), 64'(mg));
    check("chk_busy1", 64'(chk_busy1), 64'(cb1));
    check("chk_busy2", 64'(chk_busy2), 64'(cb2));
    last_p   = p_ready;
    last_m   = m_ready;
    last_cb1 = chk_busy1;
    last_cb2 = chk_busy2;
    e.we       = 1'b0;
    e.req.addr = '0;
    e.req.data = '0;
    if (pg) begin
      e.we  = (p_waddr != 0);
      e.req = '{addr: p_waddr, data: p_wdata};
    end else if (mg) begin
      e.we  = (m_waddr != 0);
      e.req = '{addr: m_waddr, data: m_wdata};
    end
    q.push_back(e);
    mwe = e.we;
    if (pg || mg) mwaddr = e.req.addr;
    rs   = rsv_valid && (rsv_addr != 0);
    merr = rs && mmask[rsv_addr] && !(mg && m_waddr == rsv_addr);
    if (mg) mmask[m_waddr] = 1'b0;
    if (rs) mmask[rsv_addr] = 1'b1;
    if (m_valid && !mg) mw = (mw == MAXW) ? mw : mw + 1;
    else                mw = 0;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      check("rf_we", 64'(rf_we), 64'(e.we));
      if (e.we) begin
        check("rf_waddr", 64'(rf_waddr), 64'(e.req.addr));
        check("rf_wdata", 64'(rf_wdata), 64'(e.req.data));
      end
    end
    check("busy_mask", 64'(busy_mask), 64'(mmask));
    check("rsv_err", 64'(rsv_err), 64'(merr));
  endtask

  initial begin
    rst_n = 1'b0;
    p_valid = 0; p_waddr = 0; p_wdata = 0;
    m_valid = 0; m_waddr = 0; m_wdata = 0;
    rsv_valid = 0; rsv_addr = 0;
    chk_addr1 = 0; chk_addr2 = 0;
    model_reset();
    #2;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_mask", 64'(busy_mask), 64'd0);
    check("rst_err", 64'(rsv_err), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // P only
    p_valid = 1; p_waddr = 5; p_wdata = 32'hDEADBEEF;
    cyc();
    check("p_only_rdy", 64'(last_p), 64'd1);
    check("p_only_we", 64'(rf_we), 64'd1);
    check("p_only_addr", 64'(rf_waddr), 64'd5);
    check("p_only_data", 64'(rf_wdata), 64'hDEADBEEF);
    p_valid = 0;
    cyc();

    // Both valid: starvation guard
    p_valid = 1; p_waddr = 3; p_wdata = 32'h11;
    m_valid = 1; m_waddr = 7; m_wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stv_p", 64'(last_p), 64'(i < 3));
      check("stv_m", 64'(last_m), 64'(i == 3));
      p_wdata = p_wdata + 1;
    end
    m_valid = 0;
    cyc();
    check("stv_m_we", 64'(rf_we), 64'd1);
    m_valid = 1; m_waddr = 8;
    cyc();
    check("stv_wrap_p", 64'(last_p), 64'd1);
    p_valid = 0;
    cyc();
    check("stv_wrap_m", 64'(last_m), 64'd1);
    m_valid = 0;
    cyc();

    // Reserve, then M writeback with in-flight hazard
    chk_addr1 = 9;
    rsv_valid = 1; rsv_addr = 9;
    cyc();
    rsv_valid = 0;
    check("rsv_set", 64'(busy_mask[9]), 64'd1);
    cyc();
    check("rsv_t1_busy", 64'(last_cb1), 64'd1);
    cyc();
    m_valid = 1; m_waddr = 9; m_wdata = 32'h99;
    cyc();
    check("rsv_t3_m", 64'(last_m), 64'd1);
    m_valid = 0;
    cyc();
    check("rsv_t4_inflight", 64'(last_cb1), 64'd1);
    cyc();
    check("rsv_t5_free", 64'(last_cb1), 64'd0);

    // Same-cycle set and clear; repeated reserve
    rsv_valid = 1; rsv_addr = 9;
    cyc();
    m_valid = 1; m_waddr = 9;
    cyc();
    check("setclr_bit", 64'(busy_mask[9]), 64'd1);
    check("setclr_err", 64'(rsv_err), 64'd0);
    m_valid = 0;
    cyc();
    check("dup_err", 64'(rsv_err), 64'd1);
    rsv_valid = 0;
    cyc();
    check("dup_err_end", 64'(rsv_err), 64'd0);
    m_valid = 1;
    cyc();
    m_valid = 0;
    cyc();

    // x0 handling
    p_valid = 1; p_waddr = 0; p_wdata = 32'h123;
    cyc();
    check("x0_rdy", 64'(last_p), 64'd1);
    check("x0_we", 64'(rf_we), 64'd0);
    p_valid = 0;
    saved_mask = busy_mask;
    rsv_valid = 1; rsv_addr = 0; chk_addr2 = 0;
    cyc();
    rsv_valid = 0;
    check("x0_rsv_mask", 64'(busy_mask), 64'(saved_mask));
    check("x0_chk", 64'(last_cb2), 64'd0);

    // Reset mid-traffic
    rsv_valid = 1; rsv_addr = 12;
    cyc();
    rsv_valid = 0;
    p_valid = 1; p_waddr = 4; p_wdata = 32'hCAFE0004;
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_mask", 64'(busy_mask), 64'd0);
    check("mid_rst_rdy", 64'(p_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc();
    check("post_rst_we", 64'(rf_we), 64'd1);
    check("post_rst_addr", 64'(rf_waddr), 64'd4);
    p_valid = 0;
    cyc();

    // Random traffic, requesters hold while stalled
    for (int i = 0; i < 400; i++) begin
      if (!(p_valid && !last_p)) begin
        p_valid = ($urandom_range(0, 2) != 0);
        p_waddr = 5'($urandom_range(0, 31));
        p_wdata = $urandom;
      end
      if (!(m_valid && !last_m)) begin
        m_valid = ($urandom_range(0, 1) != 0);
        m_waddr = 5'($urandom_range(0, 31));
        m_wdata = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'($urandom_range(0, 31));
      chk_addr1 = 5'($urandom_range(0, 31));
      chk_addr2 = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
